div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/types.sv | 32 +++
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/types.sv
// Shared type definitions for the integer pipeline: ALU operation classes,
// divider operation codes, divider FSM states and the divider step count.
package types;

    typedef enum logic [3:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_LOGIC,
        ALUOP_SHIFT,
        ALUOP_CMP,
        ALUOP_MUL,
        ALUOP_DIV
    } rv32_aluop;

    // Encoding matches funct3[1:0] of the M-extension divide group.
    typedef enum logic [1:0] {
        DIVOP_DIV  = 2'b00,
        DIVOP_DIVU = 2'b01,
        DIVOP_REM  = 2'b10,
        DIVOP_REMU = 2'b11
    } rv32_divop;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_t;

    localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration.
module div_unit
    import types::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_busy
);

    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    rv32_divop   op_q, op_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [32:0] rem_q, rem_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] result_q, result_d;

    rv32_divop   in_op;
    logic        in_signed;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [33:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
`ifdef DIV_EARLY_OUT_EN
    logic        ovf;
    logic [31:0] early_res;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;

        // funct3 values 0xx fall back to DIVU
        in_op     = i_funct3[2] ? rv32_divop'(i_funct3[1:0]) : DIVOP_DIVU;
        in_signed = (in_op == DIVOP_DIV) || (in_op == DIVOP_REM);
        a_neg     = in_signed & i_op_a[31];
        b_neg     = in_signed & i_op_b[31];
        b_zero    = (i_op_b == 32'd0);

        // Shift in the next dividend bit and trial-subtract; bit 33 is the borrow.
        diff  = {rem_q, quo_q[31]} - {2'b00, dvsr_q};
        q_fix = negq_q ? (32'd0 - quo_q) : quo_q;
        r_fix = negr_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

`ifdef DIV_EARLY_OUT_EN
        ovf       = in_signed && (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
        early_res = 32'd0;
        if (in_op == DIVOP_REM || in_op == DIVOP_REMU) begin
            early_res = b_zero ? i_op_a : 32'd0;
        end else begin
            early_res = b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
`endif

        case (state_q)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    op_d    = in_op;
                    quo_d   = a_neg ? (32'd0 - i_op_a) : i_op_a;
                    dvsr_d  = b_neg ? (32'd0 - i_op_b) : i_op_b;
                    rem_d   = 33'd0;
                    cnt_d   = 6'd0;
                    // An all-ones quotient from a zero divisor must never be negated.
                    negq_d  = (a_neg ^ b_neg) & ~b_zero;
                    negr_d  = a_neg;
                    state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (b_zero || ovf) begin
                        result_d = early_res;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                quo_d = {quo_q[30:0], ~diff[33]};
                rem_d = diff[33] ? {rem_q[31:0], quo_q[31]} : diff[32:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DIV_STEPS - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                result_d = (op_q == DIVOP_REM || op_q == DIVOP_REMU) ? r_fix : q_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            op_q     <= DIVOP_DIVU;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            rem_q    <= 33'd0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == IDLE) && !i_flush;
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = o_valid ? result_q : 32'd0;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    div_unit dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct3 (i_funct3),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    // Reference: RISC-V M-extension divide semantics in plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic want_rem;
        logic [31:0] q;
        logic [31:0] r;
        want_rem = (f3 == 3'b110) || (f3 == 3'b111);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_signed_op(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (is_signed_op(f3)) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return want_rem ? r : q;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'd0) ||
                  (is_signed_op(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        return special ? 1 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Issue one request, measure latency, optionally stall the result, then hand it off.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int stall);
        int lat;
        logic [31:0] held;
        @(negedge i_clk);
        check({name, " ready"}, 32'(o_ready), 32'd1);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_op_a   = a;
        i_op_b   = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_op_a  = $urandom;
        i_op_b  = $urandom;
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
            if (lat == 2 && !o_valid) check({name, " result idle"}, o_result, 32'd0);
        end while (!o_valid && lat < 100);
        check({name, " latency"}, 32'(lat), 32'(exp_lat(f3, a, b)));
        check({name, " result"}, o_result, exp_res);
        held = o_result;
        for (int i = 0; i < stall; i++) begin
            @(negedge i_clk);
            check({name, " stall result"}, o_result, held);
            check({name, " stall ready"}, 32'(o_ready), 32'd0);
            check({name, " stall valid"}, 32'(o_valid), 32'd1);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({name, " valid drop"}, 32'(o_valid), 32'd0);
        check({name, " result zero"}, o_result, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        logic seen;
        vecs[0]  = '{"divu 100/7",   3'b101, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{"remu 100/7",   3'b111, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{"div -7/2",     3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{"rem -7/2",     3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{"rem 7/-2",     3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[5]  = '{"div 7/-2",     3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[6]  = '{"div 5/0",      3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{"remu 5/0",     3'b111, 32'd5,          32'd0,          32'd5};
        vecs[8]  = '{"rem -5/0",     3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[9]  = '{"div ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[10] = '{"rem ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[11] = '{"divu big",     3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[12] = '{"remu big",     3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[13] = '{"f3=000 divu",  3'b000, 32'd100,        32'd7,          32'd14};

        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        i_funct3 = 3'b000;
        i_op_a   = 32'd0;
        i_op_b   = 32'd0;
        repeat (3) @(negedge i_clk);
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset result", o_result, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post-reset ready", 32'(o_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // Stalled result, then a request right after the handshake.
        run_op("stall divu", 3'b101, 32'd1000, 32'd9, 32'd111, 5);
        check("b2b ready", 32'(o_ready), 32'd1);
        run_op("b2b remu", 3'b111, 32'd1000, 32'd9, 32'd1, 0);

        // Flush mid-CALC with a competing request.
        @(negedge i_clk);
        i_valid = 1'b1; i_funct3 = 3'b101; i_op_a = 32'd1000; i_op_b = 32'd3;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        check("flush pre busy", 32'(o_busy), 32'd1);
        i_flush = 1'b1; i_valid = 1'b1; i_funct3 = 3'b100; i_op_a = 32'd9; i_op_b = 32'd3;
        #1;
        check("flush ready", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush busy", 32'(o_busy), 32'd0);
        check("flush valid", 32'(o_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid || o_busy) seen = 1'b1;
        end
        check("flush no accept", 32'(seen), 32'd0);

        // Reset mid-CALC.
        @(negedge i_clk);
        i_valid = 1'b1; i_funct3 = 3'b110; i_op_a = 32'hFFFF_0000; i_op_b = 32'd7;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("rst mid busy", 32'(o_busy), 32'd0);
        check("rst mid valid", 32'(o_valid), 32'd0);
        check("rst mid result", o_result, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst mid ready", 32'(o_ready), 32'd1);
        run_op("after rst", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel < 6) b = 32'($urandom_range(1, 20));
            else if (sel == 6) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            run_op("rand", f3, a, b, model(f3, a, b), (sel == 7) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
